// File: rtl/axis_frame_source.sv
// AXI4-Stream video test-pattern source: HSIZE x VSIZE frames with tuser/tlast
// framing and configurable horizontal/vertical blanking gaps.
module axis_frame_source #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned HSIZE      = 6,
    parameter int unsigned VSIZE      = 6,
    parameter int unsigned HBLANK     = 2,
    parameter int unsigned VBLANK     = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        cont_in,
    input  logic [1:0]  pattern_sel_in,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        frame_done_out,
    output logic        busy_out,
    output logic [15:0] frame_cnt_out
);

    localparam int unsigned XW      = (HSIZE > 1) ? $clog2(HSIZE) : 1;
    localparam int unsigned YW      = (VSIZE > 1) ? $clog2(VSIZE) : 1;
    localparam int unsigned BMAX    = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int unsigned CW      = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam int unsigned HB_LOAD = (HBLANK > 0) ? HBLANK - 1 : 0;
    localparam int unsigned VB_LOAD = (VBLANK > 0) ? VBLANK - 1 : 0;
    localparam logic [15:0] DATA_MASK = 16'((32'd1 << DATA_WIDTH) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [15:0]   lin_q, lin_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic [15:0]   data_q, data_d;
    logic          user_q, user_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic [15:0]   pix;

    // Next-state logic; a stalled beat (ACTIVE, !tready) leaves every register unchanged.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lin_d   = lin_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    pat_d   = pattern_sel_in;
                    x_d     = '0;
                    y_d     = '0;
                    lin_d   = '0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (m_axis_tready) begin
                    lin_d = lin_q + 16'd1;
                    if (x_q != XW'(HSIZE - 1)) begin
                        x_d = x_q + XW'(1);
                    end else if (y_q != YW'(VSIZE - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                        if (HBLANK != 0) begin
                            state_d = S_HBLANK;
                            cnt_d   = CW'(HB_LOAD);
                        end
                    end else begin
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                        state_d = S_VBLANK;
                        cnt_d   = CW'(VB_LOAD);
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_VBLANK: begin
                if (cnt_q == '0) begin
                    if (cont_in) begin
                        pat_d   = pattern_sel_in;
                        x_d     = '0;
                        y_d     = '0;
                        lin_d   = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from next-state values and registered, so tready never reaches them combinationally.
    always_comb begin
        pix = '0;
        case (pat_d)
            2'd0:    pix = lin_d;
            2'd1:    pix = 16'(x_d);
            2'd2:    pix = 16'(y_d);
            default: pix = 16'(x_d) ^ 16'(y_d);
        endcase
        valid_d = (state_d == S_ACTIVE);
        data_d  = valid_d ? (pix & DATA_MASK) : 16'd0;
        user_d  = valid_d && (x_d == '0) && (y_d == '0);
        last_d  = valid_d && (x_d == XW'(HSIZE - 1));
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            lin_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lin_q   <= lin_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign m_axis_tvalid  = valid_q;
    assign m_axis_tdata   = data_q;
    assign m_axis_tuser   = user_q;
    assign m_axis_tlast   = last_q;
    assign frame_done_out = done_q;
    assign busy_out       = busy_q;
    assign frame_cnt_out  = fcnt_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source: vector table for one full frame plus
// hand-written sequences for stalls, continuous mode, reset and narrow data.
module tb_axis_frame_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, cont, tready;
    logic [1:0]  sel;
    logic        valid, user, last, done, busy;
    logic [15:0] data, fcnt;

    logic        start4, tready4;
    logic        valid4, user4, last4, done4, busy4;
    logic [15:0] data4, fcnt4;

    axis_frame_source dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .cont_in(cont),
        .pattern_sel_in(sel), .m_axis_tready(tready),
        .m_axis_tvalid(valid), .m_axis_tdata(data), .m_axis_tuser(user),
        .m_axis_tlast(last), .frame_done_out(done), .busy_out(busy),
        .frame_cnt_out(fcnt)
    );

    axis_frame_source #(.DATA_WIDTH(4)) dut4 (
        .clk_in(clk), .rst_in(rst), .start_in(start4), .cont_in(1'b0),
        .pattern_sel_in(2'd0), .m_axis_tready(tready4),
        .m_axis_tvalid(valid4), .m_axis_tdata(data4), .m_axis_tuser(user4),
        .m_axis_tlast(last4), .frame_done_out(done4), .busy_out(busy4),
        .frame_cnt_out(fcnt4)
    );

    typedef struct packed {
        logic        start;
        logic        tready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_user;
        logic        exp_last;
        logic        exp_done;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    logic [15:0] bd[72];
    logic        bu[72];
    logic        bl[72];
    int          tu[3];
    int          row1[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nb, nf, nu;
        logic prev_stall;
        logic [18:0] prev_out;
        logic found;

        rst = 1'b1; start = 1'b0; cont = 1'b0; tready = 1'b1; sel = 2'd0;
        start4 = 1'b0; tready4 = 1'b1;
        row1 = '{1, 0, 3, 2, 5, 4};
        step();
        step();
        check("rst_tvalid", valid, 0);
        check("rst_tdata", data, 0);
        check("rst_tuser", user, 0);
        check("rst_tlast", last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_fcnt", fcnt, 0);
        rst = 1'b0;
        step();

        // Frame table: pattern 0, tready high, single start.
        for (int l = 0; l < 6; l++) begin
            for (int p = 0; p < 6; p++)
                tbl.push_back('{(l == 0 && p == 0), 1'b1, 1'b1, 16'(l * 6 + p),
                                (l == 0 && p == 0), (p == 5), 1'b0, 1'b1, 16'd0});
            if (l < 5)
                for (int g = 0; g < 2; g++)
                    tbl.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
        end
        for (int k = 0; k < 4; k++)
            tbl.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, (k == 0), 1'b1, 16'd1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1});

        foreach (tbl[i]) begin
            start  = tbl[i].start;
            tready = tbl[i].tready;
            step();
            check($sformatf("vec%0d", i),
                  {valid, (tbl[i].exp_valid ? data : 16'd0), user, last, done, busy, fcnt},
                  {tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_user, tbl[i].exp_last,
                   tbl[i].exp_done, tbl[i].exp_busy, tbl[i].exp_cnt});
        end
        start = 1'b0;

        // Pattern 3 with tready toggling: stalls must hold outputs.
        rst_pulse();
        sel = 2'd3; start = 1'b1; tready = 1'b0;
        step();
        start = 1'b0;
        nb = 0; prev_stall = 1'b0; prev_out = '0;
        for (int c = 0; c < 400 && nb < 36; c++) begin
            if (prev_stall) check("stall_hold", {valid, user, last, data}, prev_out);
            tready = (c % 2 == 0);
            if (valid && tready) begin
                bd[nb] = data; bu[nb] = user; bl[nb] = last;
                nb++;
            end
            prev_stall = valid && !tready;
            prev_out   = {valid, user, last, data};
            step();
        end
        check("p3_beats", nb, 36);
        check("p3_done", done, 1);
        check("p3_fcnt", fcnt, 1);
        for (int i = 0; i < nb; i++)
            check($sformatf("p3_beat%0d", i), {bd[i], bu[i], bl[i]},
                  {16'((i % 6) ^ (i / 6)), (i == 0), (i % 6 == 5)});
        for (int k = 0; k < 6; k++)
            check($sformatf("p3_row1_%0d", k), bd[6 + k], row1[k]);

        // Continuous mode: three frames, tuser spacing and frame counter.
        rst_pulse();
        sel = 2'd0; cont = 1'b1; tready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        nf = 0; nu = 0;
        for (int c = 0; c < 400 && nf < 3; c++) begin
            if (valid && user && nu < 3) begin
                tu[nu] = c;
                nu++;
            end
            if (done) begin
                nf++;
                check($sformatf("cont_fcnt%0d", nf), fcnt, nf);
                if (nf == 3) cont = 1'b0;
            end
            step();
        end
        check("cont_frames", nf, 3);
        check("cont_tusers", nu, 3);
        check("cont_period01", tu[1] - tu[0], 50);
        check("cont_period12", tu[2] - tu[1], 50);
        for (int c = 0; c < 20 && busy; c++) step();
        check("cont_busy_low", busy, 0);

        // Mid-frame start and pattern change must not disturb the running frame.
        rst_pulse();
        sel = 2'd1; cont = 1'b1; tready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        nb = 0;
        for (int c = 0; c < 400 && nb < 72; c++) begin
            start = (c == 6) || (c == 20);
            if (c == 10) sel = 2'd2;
            if (valid) begin
                bd[nb] = data; bu[nb] = user;
                nb++;
                if (user && nb > 1) cont = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("mid_beats", nb, 72);
        for (int i = 0; i < nb; i++)
            check($sformatf("mid_beat%0d", i), {bd[i], bu[i]},
                  {(i < 36) ? 16'(i % 6) : 16'((i - 36) / 6), (i % 36 == 0)});
        for (int c = 0; c < 20 && busy; c++) step();
        check("mid_busy_low", busy, 0);
        check("mid_fcnt", fcnt, 2);

        // Reset on a stalled beat at (3,2), then a fresh frame.
        rst_pulse();
        sel = 2'd0; tready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid && data == 16'd15) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("rst_found_pix32", found, 1);
        tready = 1'b0; rst = 1'b1;
        step();
        check("midrst_outputs", {valid, data, user, last, done, busy, fcnt}, '0);
        rst = 1'b0; tready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("restart_first", {valid, user, last, data, busy}, {1'b1, 1'b1, 1'b0, 16'd0, 1'b1});
        step();
        check("restart_second", {valid, user, data}, {1'b1, 1'b0, 16'd1});

        // Narrow data: 4-bit pixels wrap, upper bits stay zero.
        rst_pulse();
        tready4 = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0;
        nb = 0;
        for (int c = 0; c < 200 && nb < 36; c++) begin
            if (valid4) begin
                check($sformatf("dw4_beat%0d", nb), data4, 16'(nb % 16));
                nb++;
            end
            step();
        end
        check("dw4_beats", nb, 36);
        check("dw4_done", {done4, fcnt4}, {1'b1, 16'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
